// File: rtl/gray_codec_stream_if.sv
// Stream bundle between the environment and the Gray codec.
// The environment drives the input side and the output ready (master);
// the codec consumes the input words and produces the converted words (slave).
interface gray_codec_stream_if #(
  parameter int WIDTH = 4
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_mode;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_mode;
  logic             out_adj_err;

  modport master (
    output in_valid, in_data, in_mode, out_ready,
    input  in_ready, out_valid, out_data, out_mode, out_adj_err
  );

  modport slave (
    input  in_valid, in_data, in_mode, out_ready,
    output in_ready, out_valid, out_data, out_mode, out_adj_err
  );

endinterface

// File: rtl/gray_codec_stream.sv
// Streaming Gray <-> binary converter with a two-stage registered pipeline.
// Each word carries its own direction bit. Every word is also tracked in the
// Gray domain, so a Gray sequence that jumps by more than one bit between
// consecutive words is flagged on the output, regardless of conversion mode.
module gray_codec_stream #(
  parameter int WIDTH     = 4,
  parameter bit CHECK_ADJ = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_hist_i,
  gray_codec_stream_if.slave bus
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Stage 1 state
  logic             s1_vld_q,  s1_vld_d;
  logic [WIDTH-1:0] s1_data_q, s1_data_d;
  logic             s1_mode_q, s1_mode_d;
  logic [WIDTH-1:0] s1_gw_q,   s1_gw_d;

  // Stage 2 state (drives the outputs)
  logic             s2_vld_q,  s2_vld_d;
  logic [WIDTH-1:0] s2_data_q, s2_data_d;
  logic             s2_mode_q, s2_mode_d;
  logic             s2_err_q,  s2_err_d;

  // Adjacency history
  logic [WIDTH-1:0] last_gw_q,  last_gw_d;
  logic             hist_vld_q, hist_vld_d;

  logic             s2_load;
  logic             in_ready;
  logic             accept;
  logic [WIDTH-1:0] conv_data;
  logic [WIDTH-1:0] conv_gw;
  logic [WIDTH-1:0] gw_diff;
  logic             multi_bit;
  logic             hist_eff;
  logic             adj_err;

  // S1 advances whenever S2 is empty or its word leaves this cycle. in_ready
  // is a function of pipeline state and out_ready only, never of in_valid.
  assign s2_load  = s1_vld_q & (~s2_vld_q | bus.out_ready);
  assign in_ready = ~s1_vld_q | s2_load;
  assign accept   = bus.in_valid & in_ready;

  // Convert the incoming word and derive its Gray-domain image.
  always_comb begin
    conv_data = gray2bin(bus.in_data);
    conv_gw   = bus.in_data;
    if (bus.in_mode) begin
      conv_data = bin2gray(bus.in_data);
      conv_gw   = conv_data;
    end
  end

  // More than one differing bit <=> clearing the lowest set bit leaves bits.
  // A clear arriving with the moving word hides the stale history from it.
  always_comb begin
    gw_diff   = s1_gw_q ^ last_gw_q;
    multi_bit = |(gw_diff & (gw_diff - ONE));
    hist_eff  = hist_vld_q & ~clr_hist_i;
    adj_err   = CHECK_ADJ & hist_eff & multi_bit;
  end

  // Stage 1 next state: load on accept, empty when drained without refill.
  always_comb begin
    s1_vld_d  = s1_vld_q;
    s1_data_d = s1_data_q;
    s1_mode_d = s1_mode_q;
    s1_gw_d   = s1_gw_q;
    if (accept) begin
      s1_vld_d  = 1'b1;
      s1_data_d = conv_data;
      s1_mode_d = bus.in_mode;
      s1_gw_d   = conv_gw;
    end else if (s2_load) begin
      s1_vld_d  = 1'b0;
    end
  end

  // Stage 2 next state: load from S1, otherwise empty once accepted downstream.
  always_comb begin
    s2_vld_d  = s2_vld_q;
    s2_data_d = s2_data_q;
    s2_mode_d = s2_mode_q;
    s2_err_d  = s2_err_q;
    if (s2_load) begin
      s2_vld_d  = 1'b1;
      s2_data_d = s1_data_q;
      s2_mode_d = s1_mode_q;
      s2_err_d  = adj_err;
    end else if (s2_vld_q && bus.out_ready) begin
      s2_vld_d  = 1'b0;
    end
  end

  // History follows the words that move into S2; a moving word always
  // becomes the new reference even when a clear lands on the same cycle.
  always_comb begin
    last_gw_d  = last_gw_q;
    hist_vld_d = hist_vld_q;
    if (s2_load) begin
      last_gw_d  = s1_gw_q;
      hist_vld_d = 1'b1;
    end else if (clr_hist_i) begin
      hist_vld_d = 1'b0;
    end
  end

  // Pipeline and history registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld_q   <= 1'b0;
      s1_data_q  <= '0;
      s1_mode_q  <= 1'b0;
      s1_gw_q    <= '0;
      s2_vld_q   <= 1'b0;
      s2_data_q  <= '0;
      s2_mode_q  <= 1'b0;
      s2_err_q   <= 1'b0;
      last_gw_q  <= '0;
      hist_vld_q <= 1'b0;
    end else begin
      s1_vld_q   <= s1_vld_d;
      s1_data_q  <= s1_data_d;
      s1_mode_q  <= s1_mode_d;
      s1_gw_q    <= s1_gw_d;
      s2_vld_q   <= s2_vld_d;
      s2_data_q  <= s2_data_d;
      s2_mode_q  <= s2_mode_d;
      s2_err_q   <= s2_err_d;
      last_gw_q  <= last_gw_d;
      hist_vld_q <= hist_vld_d;
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = s2_vld_q;
  assign bus.out_data    = s2_data_q;
  assign bus.out_mode    = s2_mode_q;
  assign bus.out_adj_err = s2_err_q;

endmodule
